barcode_gen: RTL and testbench

Parametrised barcode station-ID transmitter with a queued frame buffer, the successor to the single-shot barcode mimic used around the Follower. It serialises station IDs onto the single-wire `BC` line in pulse-width-coded cells. Queued requests play back to back with a guaranteed idle gap between frames. It sits on the stimulus side of the Follower's `BC` input, and also serves as a standalone station beacon in system benches.

---
 rtl/barcode_gen.sv | 169 ++++++++++++++++
 tb/tb_barcode_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/barcode_gen.sv
// barcode_gen: queued station-ID transmitter that serialises IDs onto the single-wire BC line
// as pulse-width-coded cells (start cell, ID_W data cells MSB first, optional even-parity cell).
// Latency: send at edge k -> LOAD at edge k+1 -> BC falls after edge k+2; frames are separated by GAP idle clocks plus LOAD.
// Backpressure: DEPTH-entry queue; a send while full with no pop in the same cycle is dropped and overflow pulses.
// Optional feature: define BC_PARITY_EN to append an even-parity cell after the data cells.
// Ports: clk, rst_n (async active-low); period/send/station_ID in; BC, BC_done, busy, full, empty, overflow out.
module barcode_gen #(
  parameter int ID_W  = 8,
  parameter int DEPTH = 4,
  parameter int PER_W = 22,
  parameter int GAP   = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PER_W-1:0] period,
  input  logic             send,
  input  logic [ID_W-1:0]  station_ID,
  output logic             BC,
  output logic             BC_done,
  output logic             busy,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP + 1);
`ifdef BC_PARITY_EN
  localparam int NCELL = ID_W + 2;
`else
  localparam int NCELL = ID_W + 1;
`endif
  localparam int CW = $clog2(NCELL + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_LO   = 3'd2;
  localparam logic [2:0] S_HI   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]       state_q, state_d;
  logic [PER_W-1:0] cnt_q, cnt_d, p_q, p_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [CW-1:0]    cell_q, cell_d;
  logic [ID_W-1:0]  sreg_q, sreg_d;
  logic             par_q, par_d;
  logic             bc_q, bc_d, done_q, done_d, busy_q, busy_d, ovf_q, ovf_d;

  logic             pop, push_ok, cur_bit, last_cell;
  logic [ID_W-1:0]  head;
  logic [PER_W-1:0] lo_w, p_clamped;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign pop     = (state_q == S_LOAD);
  // A pop in the same cycle frees the slot being written, so a full queue still accepts.
  assign push_ok = send && (!full || pop);

  assign p_clamped = (period < PER_W'(4)) ? PER_W'(4) : period;
  assign last_cell = (cell_q == CW'(NCELL - 1));
`ifdef BC_PARITY_EN
  assign cur_bit = last_cell ? par_q : sreg_q[ID_W-1];
`else
  assign cur_bit = sreg_q[ID_W-1];
`endif
  assign lo_w = (cell_q == '0) ? (p_q >> 1) :
                cur_bit        ? (p_q >> 2) : (p_q - (p_q >> 2));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    cell_d   = cell_q;
    sreg_d   = sreg_q;
    par_d    = par_q;
    p_d      = p_q;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_LOAD;
      S_LOAD: begin
        sreg_d  = head;
        par_d   = ^head;
        p_d     = p_clamped;
        cell_d  = '0;
        cnt_d   = '0;
        state_d = S_LO;
      end
      // cnt runs 0..P-1 across the whole cell; LO owns the first lo_w counts.
      S_LO: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == lo_w - 1'b1) state_d = S_HI;
      end
      S_HI: begin
        if (cnt_q == p_q - 1'b1) begin
          cnt_d = '0;
          if (last_cell) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            state_d = S_LO;
            cell_d  = cell_q + 1'b1;
            // The start cell carries no data, so the first shift follows the first data cell.
            if (cell_q != '0) sreg_d = sreg_q << 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(GAP - 1)) state_d = empty ? S_IDLE : S_LOAD;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered from the next-state view so they line up with the state they describe.
    bc_d   = (state_d != S_LO);
    done_d = (state_d == S_HI) && (cnt_d == p_d - 1'b1) && (cell_d == CW'(NCELL - 1));
    busy_d = (state_d != S_IDLE);
    ovf_d  = send && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= station_ID;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      gap_q    <= '0;
      cell_q   <= '0;
      sreg_q   <= '0;
      par_q    <= 1'b0;
      p_q      <= '0;
      bc_q     <= 1'b1;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gap_q    <= gap_d;
      cell_q   <= cell_d;
      sreg_q   <= sreg_d;
      par_q    <= par_d;
      p_q      <= p_d;
      bc_q     <= bc_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign BC       = bc_q;
  assign BC_done  = done_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_barcode_gen.sv
// tb_barcode_gen: directed checks of barcode_gen (ID_W=8, DEPTH=4, PER_W=22, GAP=64).
// Frames are decoded by measuring low/high widths of every cell at the falling clock edge.
// Honours BC_PARITY_EN to decide whether a parity cell is expected.
module tb_barcode_gen;
  localparam int GAPC = 64;
`ifdef BC_PARITY_EN
  localparam int NCELL = 10;
`else
  localparam int NCELL = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [21:0] period = '0;
  logic        send = 1'b0;
  logic [7:0]  station_ID = '0;
  logic        BC, BC_done, busy, full, empty, overflow;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_fall = 0;
  int last_done = 0;
  int prev_done = 0;

  barcode_gen #(.ID_W(8), .DEPTH(4), .PER_W(22), .GAP(GAPC)) dut (
    .clk(clk), .rst_n(rst_n), .period(period), .send(send), .station_ID(station_ID),
    .BC(BC), .BC_done(BC_done), .busy(busy), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Decode one frame; 'pre' = low samples of the start cell already passed before the call.
  task automatic rx_frame(input string tag, input int p, input logic [7:0] id, input int pre);
    int w, lo, hi, exp_lo, done_cnt;
    logic b, done_end;
    w = 0;
    while (BC !== 1'b0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    check({tag, " start"}, BC, 0);
    last_fall = cyc - pre;
    done_cnt = 0;
    done_end = 1'b0;
    for (int c = 0; c < NCELL; c++) begin
      if (c == 0) exp_lo = p >> 1;
      else begin
        if (c <= 8) b = id[8-c];
        else b = ^id;
        exp_lo = b ? (p >> 2) : (p - (p >> 2));
      end
      lo = (c == 0) ? pre : 0;
      while (BC === 1'b0 && lo < p) begin
        done_cnt += int'(BC_done);
        lo++;
        @(negedge clk);
      end
      hi = 0;
      while (BC === 1'b1 && lo + hi < p) begin
        done_cnt += int'(BC_done);
        if (lo + hi == p - 1) begin
          done_end = BC_done;
          last_done = cyc;
        end
        hi++;
        @(negedge clk);
      end
      check($sformatf("%s cell%0d low", tag, c), lo, exp_lo);
      check($sformatf("%s cell%0d high", tag, c), hi, p - exp_lo);
    end
    check({tag, " done count"}, done_cnt, 1);
    check({tag, " done at end"}, done_end, 1);
    check({tag, " frame length"}, last_done - last_fall + 1, NCELL * p);
    check({tag, " idle after frame"}, BC, 1);
  endtask

  initial begin
    // Reset state
    #1 rst_n = 1'b0;
    #1;
    check("rst BC", BC, 1);
    check("rst BC_done", BC_done, 0);
    check("rst busy", busy, 0);
    check("rst full", full, 0);
    check("rst empty", empty, 1);
    check("rst overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame, period 4096, ID 0x01
    period = 22'h1000; station_ID = 8'h01; send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check("t1 empty after send", empty, 0);
    check("t1 busy before load", busy, 0);
    @(negedge clk);
    check("t1 busy at load", busy, 1);
    check("t1 BC at load", BC, 1);
    @(negedge clk);
    check("t1 BC falls", BC, 0);
    rx_frame("t1", 4096, 8'h01, 0);
    repeat (GAPC - 1) @(negedge clk);
    check("t1 busy end of gap", busy, 1);
    @(negedge clk);
    check("t1 busy idle", busy, 0);

    // Four back-to-back sends, period 16
    period = 22'd16; station_ID = 8'hA5; send = 1'b1;
    @(negedge clk); station_ID = 8'h3C;
    @(negedge clk); station_ID = 8'hFF;
    @(negedge clk); station_ID = 8'h00;
    @(negedge clk); send = 1'b0;
    check("t2 empty", empty, 0);
    check("t2 full (one popped)", full, 0);
    rx_frame("t2 A5", 16, 8'hA5, 1);
    prev_done = last_done;
    rx_frame("t2 3C", 16, 8'h3C, 0);
    check("t2 gap 3C", last_fall - prev_done, GAPC + 2);
    prev_done = last_done;
    rx_frame("t2 FF", 16, 8'hFF, 0);
    check("t2 gap FF", last_fall - prev_done, GAPC + 2);
    check("t2 empty before 4th load", empty, 0);
    prev_done = last_done;
    rx_frame("t2 00", 16, 8'h00, 0);
    check("t2 gap 00", last_fall - prev_done, GAPC + 2);
    check("t2 empty after 4th load", empty, 1);
    repeat (GAPC) @(negedge clk);
    check("t2 busy idle", busy, 0);

    // Overflow, then push concurrent with a LOAD pop
    station_ID = 8'h11; send = 1'b1;
    @(negedge clk); send = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t3 frame 11 running", BC, 0);
    send = 1'b1; station_ID = 8'h22;
    @(negedge clk); station_ID = 8'h33;
    @(negedge clk); station_ID = 8'h44;
    @(negedge clk); station_ID = 8'h55;
    @(negedge clk); send = 1'b0;
    check("t3 full", full, 1);
    check("t3 no overflow yet", overflow, 0);
    send = 1'b1; station_ID = 8'h77;
    @(negedge clk); send = 1'b0;
    check("t3 overflow pulse", overflow, 1);
    check("t3 still full", full, 1);
    @(negedge clk);
    check("t3 overflow one cycle", overflow, 0);
    begin
      int w;
      w = 0;
      while (BC_done !== 1'b1 && w < 2000) begin
        @(negedge clk);
        w++;
      end
    end
    check("t3 frame 11 done", BC_done, 1);
    repeat (GAPC + 1) @(negedge clk);
    check("t3 busy at load", busy, 1);
    check("t3 BC at load", BC, 1);
    check("t3 full at load", full, 1);
    send = 1'b1; station_ID = 8'h66;
    @(negedge clk); send = 1'b0;
    check("t3 BC after load", BC, 0);
    check("t3 full after push+pop", full, 1);
    check("t3 no overflow on push+pop", overflow, 0);
    rx_frame("t3 22", 16, 8'h22, 0);
    prev_done = last_done;
    rx_frame("t3 33", 16, 8'h33, 0);
    check("t3 gap 33", last_fall - prev_done, GAPC + 2);
    prev_done = last_done;
    rx_frame("t3 44", 16, 8'h44, 0);
    check("t3 gap 44", last_fall - prev_done, GAPC + 2);
    prev_done = last_done;
    rx_frame("t3 55", 16, 8'h55, 0);
    check("t3 gap 55", last_fall - prev_done, GAPC + 2);
    prev_done = last_done;
    rx_frame("t3 66", 16, 8'h66, 0);
    check("t3 gap 66", last_fall - prev_done, GAPC + 2);
    check("t3 empty", empty, 1);
    repeat (GAPC) @(negedge clk);
    check("t3 busy idle", busy, 0);
    check("t3 BC idle", BC, 1);

    // Period clamp: period 2 -> 4-clock cells
    period = 22'd2; station_ID = 8'h5A; send = 1'b1;
    @(negedge clk); send = 1'b0;
    rx_frame("clamp 5A", 4, 8'h5A, 0);
    repeat (GAPC) @(negedge clk);
    check("clamp busy idle", busy, 0);

    // Parity cell (present only with BC_PARITY_EN)
    period = 22'd16; station_ID = 8'h07; send = 1'b1;
    @(negedge clk); send = 1'b0;
    rx_frame("par 07", 16, 8'h07, 0);
    repeat (GAPC) @(negedge clk);
    check("par busy idle", busy, 0);

    // Reset mid data cell with a second ID still queued
    period = 22'd16; station_ID = 8'hF0; send = 1'b1;
    @(negedge clk); station_ID = 8'h0F;
    @(negedge clk); send = 1'b0;
    @(negedge clk);
    check("rst2 frame start", BC, 0);
    repeat (17) @(negedge clk);
    check("rst2 mid data cell low", BC, 0);
    check("rst2 queue non-empty", empty, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst2 BC async high", BC, 1);
    check("rst2 BC_done", BC_done, 0);
    check("rst2 busy", busy, 0);
    check("rst2 full", full, 0);
    check("rst2 empty", empty, 1);
    check("rst2 overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst2 empty after release", empty, 1);
    check("rst2 busy after release", busy, 0);
    check("rst2 BC after release", BC, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
